ahb_slave_resp_ctrl: RTL and testbench

//  AHB slave-side transfer controller between the AHB slave bus and a simple req/ack memory backend.
//  - Captures address phases and range/size-checks them.
//  - Sequences backend accesses and inserts wait states on hreadyout.
//  - Drives OKAY or the two-cycle ERROR response on hresp.

---
 rtl/ahb_slave_resp_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ahb_slave_resp_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_resp_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_slave_resp_ctrl
//
// AHB slave-side transfer controller sitting between the AHB slave bus and a
// simple req/ack memory backend. It captures address phases, range/size checks
// them, sequences the backend access, inserts wait states on hreadyout and
// drives either an OKAY or the two-cycle ERROR response on hresp.
//
// Optional feature macro: AHB_SLAVE_TIMEOUT_EN
//   defined   : an ACCESS that sees no mem_ack for TIMEOUT_CYCLES cycles is
//               abandoned (mem_req drops) and answered with ERROR.
//   undefined : ACCESS waits indefinitely for mem_ack.
//
// Ports
//   hclk, hresetn          bus clock, asynchronous active-low reset
//   hselx, hready, htrans  slave select, bus HREADY, transfer type
//   haddr, hwrite, hsize   address-phase attributes
//   hwdata, hwstrb         write data / strobes (data phase)
//   hreadyout, hresp       registered slave ready / response (0=OKAY 1=ERROR)
//   hrdata                 registered read data
//   mem_req, mem_we        registered backend request / write enable
//   mem_addr               registered captured address
//   mem_wdata, mem_wstrb   hwdata/hwstrb passed through while mem_req is high
//   mem_ack, mem_rdata     backend completion pulse / read data
//   mem_err                backend error, qualified by mem_ack
// ---------------------------------------------------------------------------
module ahb_slave_resp_ctrl #(
  parameter int unsigned     ADDR_WIDTH     = 32,
  parameter int unsigned     DATA_WIDTH     = 32,
  parameter longint unsigned BASE_ADDR      = 64'h0000_0000,
  parameter longint unsigned REGION_SIZE    = 64'h0001_0000,
  parameter int unsigned     MIN_WAIT       = 1,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hselx,
  input  logic                    hready,
  input  logic [1:0]              htrans,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_err
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0]  MAX_HSIZE  = 3'($clog2(STRB_WIDTH));
  localparam logic [3:0]  MIN_WAIT_C = 4'(MIN_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RESP   = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic                    ack_seen_q, ack_seen_d;
  logic                    err_seen_q, err_seen_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [63:0]             haddr_ext_s;
  logic                    in_range_s;
  logic                    cap_s;
  logic                    cap_bad_s;
  logic                    ack_now_s;
  logic                    ack_any_s;
  logic                    err_any_s;
  logic [3:0]              wait_inc_s;
  logic                    unused_ok;

`ifdef AHB_SLAVE_TIMEOUT_EN
  localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic                        tmo_hit_s;
`else
  // Timeout depth is only meaningful when the timeout feature is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_param_unused
  end
`endif

  // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  assign unused_ok = htrans[0];

  // Subtract only after the lower bound holds so the span test cannot wrap.
  assign haddr_ext_s = 64'(haddr);
  assign in_range_s  = (haddr_ext_s >= BASE_ADDR) &&
                       ((haddr_ext_s - BASE_ADDR) < REGION_SIZE);

  // Write data is a data-phase signal, so it is forwarded rather than stored.
  assign mem_wdata = mem_req_q ? hwdata : {DATA_WIDTH{1'b0}};
  assign mem_wstrb = mem_req_q ? hwstrb : {STRB_WIDTH{1'b0}};

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    wait_cnt_d  = wait_cnt_q;
    ack_seen_d  = ack_seen_q;
    err_seen_d  = err_seen_q;
    rdata_d     = rdata_q;
`ifdef AHB_SLAVE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    // New address phases are only accepted when the previous data phase ends.
    cap_s = hselx && hready && htrans[1] &&
            ((state_q == ST_IDLE) || (state_q == ST_RESP) || (state_q == ST_ERR2));
    cap_bad_s = (!in_range_s) || (hsize > MAX_HSIZE);

    // An ack only counts while a request is outstanding; strays are dropped.
    ack_now_s  = mem_ack && mem_req_q && (state_q == ST_ACCESS);
    ack_any_s  = ack_now_s || ack_seen_q;
    err_any_s  = ack_now_s ? mem_err : err_seen_q;
    // Count includes the current cycle so MIN_WAIT=1 means one wait state.
    wait_inc_s = (wait_cnt_q == 4'hF) ? 4'hF : (wait_cnt_q + 4'd1);
`ifdef AHB_SLAVE_TIMEOUT_EN
    tmo_hit_s  = (!ack_any_s) && ((tmo_cnt_q + TMO_W'(1)) >= TMO_LIMIT);
`endif

    case (state_q)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        mem_req_d = 1'b0;
        if (cap_s) begin
          wait_cnt_d = 4'd0;
          ack_seen_d = 1'b0;
          err_seen_d = 1'b0;
`ifdef AHB_SLAVE_TIMEOUT_EN
          tmo_cnt_d  = {TMO_W{1'b0}};
`endif
          if (cap_bad_s) begin
            state_d = ST_ERR1;
          end else begin
            state_d    = ST_ACCESS;
            mem_req_d  = 1'b1;
            mem_we_d   = hwrite;
            mem_addr_d = haddr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        wait_cnt_d = wait_inc_s;
        if (ack_now_s) begin
          mem_req_d  = 1'b0;
          ack_seen_d = 1'b1;
          err_seen_d = mem_err;
          rdata_d    = mem_rdata;
        end else begin
          mem_req_d  = mem_req_q;
        end
`ifdef AHB_SLAVE_TIMEOUT_EN
        tmo_cnt_d = ack_any_s ? tmo_cnt_q : (tmo_cnt_q + TMO_W'(1));
`endif
        if (ack_any_s && (wait_inc_s >= MIN_WAIT_C)) begin
          mem_req_d = 1'b0;
          if (err_any_s) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_RESP;
            // Writes leave the last read value on hrdata.
            if (!mem_we_q) begin
              hrdata_d = ack_now_s ? mem_rdata : rdata_q;
            end else begin
              hrdata_d = hrdata_q;
            end
          end
        end
`ifdef AHB_SLAVE_TIMEOUT_EN
        else if (tmo_hit_s) begin
          mem_req_d = 1'b0;
          state_d   = ST_ERR1;
        end
`endif
        else begin
          state_d = ST_ACCESS;
        end
      end

      ST_ERR1: begin
        mem_req_d = 1'b0;
        state_d   = ST_ERR2;
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Bus response is a pure function of the state being entered.
    case (state_d)
      ST_ACCESS: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b0;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
    endcase
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= {DATA_WIDTH{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      wait_cnt_q  <= 4'd0;
      ack_seen_q  <= 1'b0;
      err_seen_q  <= 1'b0;
      rdata_q     <= {DATA_WIDTH{1'b0}};
`ifdef AHB_SLAVE_TIMEOUT_EN
      tmo_cnt_q   <= {TMO_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      wait_cnt_q  <= wait_cnt_d;
      ack_seen_q  <= ack_seen_d;
      err_seen_q  <= err_seen_d;
      rdata_q     <= rdata_d;
`ifdef AHB_SLAVE_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_slave_resp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_resp_ctrl
//
// Directed bench for ahb_slave_resp_ctrl with default parameters
// (BASE 0, REGION 0x10000, MIN_WAIT 1, 32-bit data). A table of per-cycle
// input/expected-output records covers the single-cycle behaviour; separate
// sequences cover mid-transfer reset and the ack timeout / indefinite stall.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ahb_slave_resp_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hselx;
  logic        hready;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  ahb_slave_resp_ctrl dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hselx     (hselx),
    .hready    (hready),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hwstrb    (hwstrb),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        hsel;
    logic        hrdy;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        e_hro;
    logic        e_hresp;
    logic [31:0] e_hrdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle(input logic rdy);
    hselx = 1'b0; hready = rdy; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
    hsize = 3'd0; hwdata = 32'h0; hwstrb = 4'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hselx = v.hsel; hready = v.hrdy; htrans = v.trans; haddr = v.addr;
    hwrite = v.wr; hsize = v.size; hwdata = v.wdata; hwstrb = v.wstrb;
    mem_ack = v.ack; mem_rdata = v.rdata; mem_err = v.err;
  endtask

  initial begin
    int low_cnt;
    int req_cnt;
    int guard;

    // Per-cycle table. Expected values are the outputs after the next rising edge.
    //               hsel hrdy  trans  addr          wr    size  wdata         wstrb  ack   rdata         err   hro   hresp hrdata        req   we    maddr
    // read 0x10, ack in first wait cycle
    vq.push_back('{1'b1,1'b1,2'b10,32'h0000_0010,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0010});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b1,32'hA5A5_0001,1'b0,1'b1,1'b0,32'hA5A5_0001,1'b0,1'b0,32'h0000_0010});
    vq.push_back('{1'b0,1'b1,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'hA5A5_0001,1'b0,1'b0,32'h0000_0010});
    // write at BASE+REGION_SIZE: out of range, two-cycle ERROR, no request
    vq.push_back('{1'b1,1'b1,2'b10,32'h0001_0000,1'b1,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'hA5A5_0001,1'b0,1'b0,32'h0000_0010});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hA5A5_0001,1'b0,1'b0,32'h0000_0010});
    vq.push_back('{1'b0,1'b1,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'hA5A5_0001,1'b0,1'b0,32'h0000_0010});
    // NONSEQ read of last in-range word, SEQ read pipelined behind it
    vq.push_back('{1'b1,1'b1,2'b10,32'h0000_FFFC,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'hA5A5_0001,1'b1,1'b0,32'h0000_FFFC});
    vq.push_back('{1'b1,1'b0,2'b11,32'h0000_0020,1'b0,3'd2,32'h0,        4'h0,1'b1,32'h1111_2222,1'b0,1'b1,1'b0,32'h1111_2222,1'b0,1'b0,32'h0000_FFFC});
    vq.push_back('{1'b1,1'b1,2'b11,32'h0000_0020,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h1111_2222,1'b1,1'b0,32'h0000_0020});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h1111_2222,1'b1,1'b0,32'h0000_0020});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h1111_2222,1'b1,1'b0,32'h0000_0020});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b1,32'h3333_4444,1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b0,32'h0000_0020});
    vq.push_back('{1'b0,1'b1,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b0,32'h0000_0020});
    // hsize=3 on a 32-bit slave is an error
    vq.push_back('{1'b1,1'b1,2'b10,32'h0000_0040,1'b0,3'd3,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h3333_4444,1'b0,1'b0,32'h0000_0020});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h3333_4444,1'b0,1'b0,32'h0000_0020});
    // write captured in ERR2; backend answers with mem_err -> ERROR
    vq.push_back('{1'b1,1'b1,2'b10,32'h0000_0044,1'b1,3'd2,32'hDEAD_BEEF,4'hF,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h3333_4444,1'b1,1'b1,32'h0000_0044});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'hCAFE_F00D,4'h3,1'b1,32'h0,        1'b1,1'b0,1'b1,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    // BUSY with hselx=1: zero-wait OKAY, no request
    vq.push_back('{1'b1,1'b1,2'b01,32'h0000_0048,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    vq.push_back('{1'b1,1'b1,2'b01,32'h0000_0048,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    // NONSEQ with hready=0 is not captured
    vq.push_back('{1'b1,1'b0,2'b10,32'h0000_0080,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    // stray ack while idle is ignored
    vq.push_back('{1'b0,1'b1,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b1,32'hFFFF_0000,1'b1,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    // NONSEQ without hselx is not captured
    vq.push_back('{1'b0,1'b1,2'b10,32'h0000_0084,1'b0,3'd2,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0044});
    // good write: hrdata keeps last read value
    vq.push_back('{1'b1,1'b1,2'b10,32'h0000_0008,1'b1,3'd2,32'h1234_5678,4'hF,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h3333_4444,1'b1,1'b1,32'h0000_0008});
    vq.push_back('{1'b0,1'b0,2'b00,32'h0,        1'b0,3'd0,32'h1234_5678,4'hC,1'b1,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0008});
    vq.push_back('{1'b0,1'b1,2'b00,32'h0,        1'b0,3'd0,32'h0,        4'h0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h3333_4444,1'b0,1'b1,32'h0000_0008});

    // ---------------- reset state ----------------
    hresetn = 1'b0;
    bus_idle(1'b1);
    repeat (2) @(negedge hclk);
    chk("rst hreadyout", 64'(hreadyout), 64'(1'b1));
    chk("rst hresp",     64'(hresp),     64'(1'b0));
    chk("rst hrdata",    64'(hrdata),    64'(32'h0));
    chk("rst mem_req",   64'(mem_req),   64'(1'b0));
    chk("rst mem_we",    64'(mem_we),    64'(1'b0));
    chk("rst mem_addr",  64'(mem_addr),  64'(32'h0));
    hresetn = 1'b1;
    @(negedge hclk);

    // ---------------- reset in the middle of ACCESS ----------------
    hselx = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = 32'h0000_0030;
    hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    chk("midrst pre mem_req", 64'(mem_req), 64'(1'b1));
    bus_idle(1'b0);
    #2 hresetn = 1'b0;
    #1;
    chk("midrst mem_req",   64'(mem_req),   64'(1'b0));
    chk("midrst hreadyout", 64'(hreadyout), 64'(1'b1));
    chk("midrst hresp",     64'(hresp),     64'(1'b0));
    chk("midrst mem_addr",  64'(mem_addr),  64'(32'h0));
    @(negedge hclk);
    hresetn = 1'b1;
    hready = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    @(negedge hclk);
    chk("stray ack hreadyout", 64'(hreadyout), 64'(1'b1));
    chk("stray ack hresp",     64'(hresp),     64'(1'b0));
    chk("stray ack hrdata",    64'(hrdata),    64'(32'h0));
    chk("stray ack mem_req",   64'(mem_req),   64'(1'b0));
    bus_idle(1'b1);
    @(negedge hclk);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      @(negedge hclk);
      chk($sformatf("v%0d hreadyout", i), 64'(hreadyout), 64'(vq[i].e_hro));
      chk($sformatf("v%0d hresp", i),     64'(hresp),     64'(vq[i].e_hresp));
      chk($sformatf("v%0d hrdata", i),    64'(hrdata),    64'(vq[i].e_hrdata));
      chk($sformatf("v%0d mem_req", i),   64'(mem_req),   64'(vq[i].e_req));
      chk($sformatf("v%0d mem_we", i),    64'(mem_we),    64'(vq[i].e_we));
      chk($sformatf("v%0d mem_addr", i),  64'(mem_addr),  64'(vq[i].e_addr));
      chk($sformatf("v%0d mem_wdata", i), 64'(mem_wdata), 64'(vq[i].e_req ? vq[i].wdata : 32'h0));
      chk($sformatf("v%0d mem_wstrb", i), 64'(mem_wstrb), 64'(vq[i].e_req ? vq[i].wstrb : 4'h0));
    end

    // ---------------- backend never acks ----------------
    bus_idle(1'b1);
    hselx = 1'b1; htrans = 2'b10; haddr = 32'h0000_0050; hsize = 3'd2;
    @(negedge hclk);
    bus_idle(1'b0);
`ifdef AHB_SLAVE_TIMEOUT_EN
    req_cnt = 0;
    guard   = 0;
    while ((mem_req === 1'b1) && (guard < 40)) begin
      req_cnt++;
      guard++;
      @(negedge hclk);
    end
    chk("tmo req cycles",   64'(req_cnt),   64'(16));
    chk("tmo err1 hready",  64'(hreadyout), 64'(1'b0));
    chk("tmo err1 hresp",   64'(hresp),     64'(1'b1));
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(negedge hclk);
    chk("tmo err2 hready",  64'(hreadyout), 64'(1'b1));
    chk("tmo err2 hresp",   64'(hresp),     64'(1'b1));
    chk("tmo err2 mem_req", 64'(mem_req),   64'(1'b0));
    bus_idle(1'b1);
    @(negedge hclk);
    chk("tmo idle hready",  64'(hreadyout), 64'(1'b1));
    chk("tmo idle hresp",   64'(hresp),     64'(1'b0));
    chk("tmo idle hrdata",  64'(hrdata),    64'(32'h3333_4444));
`else
    low_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      if ((hreadyout === 1'b0) && (mem_req === 1'b1)) begin
        low_cnt++;
      end
      @(negedge hclk);
    end
    chk("stall low cycles", 64'(low_cnt), 64'(120));
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(negedge hclk);
    chk("stall resp hready", 64'(hreadyout), 64'(1'b1));
    chk("stall resp hresp",  64'(hresp),     64'(1'b0));
    chk("stall resp hrdata", 64'(hrdata),    64'(32'h0BAD_CAFE));
    chk("stall resp mem_req", 64'(mem_req),  64'(1'b0));
    bus_idle(1'b1);
    @(negedge hclk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
